ram_lsu: RTL and testbench

Load/store unit that acts as the initiator on the data port of the 128×16 unified RAM. It accepts single-word memory requests from the CPU pipeline over a valid/ready handshake and drives the RAM data port (address, write enable, write data). It absorbs the port's one-cycle synchronous read latency and returns results over a second valid/ready channel. It also performs in-memory read-modify-write operations (ADD/AND/OR/XOR/SWAP) so the pipeline never holds a port across cycles; the RAM instruction-fetch port is untouched.

---
 rtl/ram_lsu_pkg.sv | 26 ++
 rtl/ram_lsu_if.sv | 27 ++
 rtl/ram_lsu_rmw_alu.sv | 23 ++
 rtl/ram_lsu.sv | 93 +++++++++
 tb/tb_ram_lsu.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ram_lsu_pkg.sv
// Shared definitions for the RAM load/store unit and its in-memory-compute ALU.
package ram_lsu_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_XOR   = 3'd5,
    OP_SWAP  = 3'd6,
    OP_NOP   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RSP
  } state_e;

endpackage

// File: rtl/ram_lsu_if.sv
// Request/response channels plus RAM data port; slave = LSU view, master = pipeline/RAM view.
interface ram_lsu_if;
  import ram_lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_lsu_rmw_alu.sv
// Combinational read-modify-write datapath: new word from old word and operand.
module rmw_alu
  import ram_lsu_pkg::*;
(
  input  op_e               op_i,
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = old_i;
    case (op_i)
      OP_ADD:  result_o = old_i + operand_i;
      OP_AND:  result_o = old_i & operand_i;
      OP_OR:   result_o = old_i | operand_i;
      OP_XOR:  result_o = old_i ^ operand_i;
      OP_SWAP: result_o = operand_i;
      default: result_o = old_i;
    endcase
  end

endmodule

// File: rtl/ram_lsu.sv
// Load/store unit on the RAM data port: single-word LOAD/STORE plus in-memory RMW/SWAP.
module ram_lsu
  import ram_lsu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  ram_lsu_if.slave bus
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic [DATA_W-1:0] alu_res;

  rmw_alu u_alu (
    .op_i      (op_q),
    .old_i     (bus.mem_rdata),
    .operand_i (opnd_q),
    .result_o  (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      opnd_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      opnd_q  <= opnd_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end

  // addr_q/wdata_q drive the RAM port directly, so they only move when an access needs them.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    opnd_d  = opnd_q;
    wdata_d = wdata_q;
    rsp_d   = rsp_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d = op_e'(bus.req_op);
          case (op_e'(bus.req_op))
            OP_NOP: state_d = S_IDLE;
            OP_STORE: begin
              addr_d  = bus.req_addr;
              wdata_d = bus.req_wdata;
              state_d = S_WR;
            end
            default: begin
              addr_d  = bus.req_addr;
              opnd_d  = bus.req_wdata;
              state_d = S_RD;
            end
          endcase
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        rsp_d = bus.mem_rdata;
        if (op_q == OP_LOAD) begin
          state_d = S_RSP;
        end else begin
          wdata_d = alu_res;
          state_d = S_WR;
        end
      end
      S_WR:  state_d = (op_q == OP_STORE) ? S_IDLE : S_RSP;
      S_RSP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RSP);
  assign bus.rsp_data  = rsp_q;
  assign bus.mem_we    = (state_q == S_WR);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_ram_lsu.sv
// Directed bench for ram_lsu against a 128x16 synchronous-read RAM model.
module tb_ram_lsu;

  logic clk;
  logic rst_n;
  int unsigned nvec;
  int unsigned nmis;
  int unsigned total_we;

  ram_lsu_if bus ();

  ram_lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [15:0] mem [128];
  logic        pre_we;
  logic [6:0]  pre_addr;
  logic [15:0] pre_data;

  // Read-before-write RAM; pre_* is a bench-only backdoor used while the DUT is in reset.
  always @(posedge clk) begin
    if (pre_we)           mem[pre_addr]     <= pre_data;
    else if (bus.mem_we)  mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(negedge clk) if (bus.mem_we) total_we++;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [6:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Starts and ends on a falling edge; n counts cycles after the accepting edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [6:0] addr,
                        input logic [15:0] wd, input int unsigned hold,
                        output int unsigned lat, output int unsigned rdy_n,
                        output logic [15:0] data, output int unsigned wes,
                        output int unsigned we_n, output logic [15:0] we_data);
    bit done;
    lat = 0; rdy_n = 0; data = '0; wes = 0; we_n = 0; we_data = '0; done = 1'b0;
    check({tag, "/req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        wes++;
        we_n    = n;
        we_data = bus.mem_wdata;
        check({tag, "/we_addr"}, {25'd0, bus.mem_addr}, {25'd0, addr});
      end
      if (bus.rsp_valid) begin
        lat  = n;
        data = bus.rsp_data;
        done = 1'b1;
        check({tag, "/busy_in_rsp"}, {31'd0, bus.req_ready}, 32'd0);
      end else if (bus.req_ready) begin
        rdy_n = n;
        done  = 1'b1;
      end
    end
    check({tag, "/done"}, {31'd0, done}, 32'd1);
    if (lat != 0) begin
      for (int h = 0; h < int'(hold); h++) begin
        @(negedge clk);
        check({tag, "/hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, "/hold_data"},  {16'd0, bus.rsp_data}, {16'd0, data});
        check({tag, "/hold_ready"}, {31'd0, bus.req_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      @(negedge clk);
      check({tag, "/ready_after"}, {31'd0, bus.req_ready}, 32'd1);
      check({tag, "/valid_after"}, {31'd0, bus.rsp_valid}, 32'd0);
    end
  endtask

  int unsigned lat, rdy_n, wes, we_n, we0;
  logic [15:0] data, we_data;

  initial begin
    nvec = 0; nmis = 0; total_we = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.req_valid = 1'b0; bus.req_op = 3'd7; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    poke(7'd29,  16'd22);
    poke(7'd30,  16'hFFFF);
    poke(7'd7,   16'h0F0F);
    poke(7'd5,   16'h5555);
    poke(7'd40,  16'h0100);
    poke(7'd127, 16'hBEEF);
    poke(7'd0,   16'h1357);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst/rsp_data",  {16'd0, bus.rsp_data}, 32'd0);
    check("rst/mem_we",    {31'd0, bus.mem_we}, 32'd0);
    check("rst/mem_addr",  {25'd0, bus.mem_addr}, 32'd0);
    check("rst/mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);

    run_op("load29", 3'd0, 7'd29, 16'h0000, 0, lat, rdy_n, data, wes, we_n, we_data);
    check("load29/lat",  lat, 32'd3);
    check("load29/data", {16'd0, data}, 32'd22);
    check("load29/wes",  wes, 32'd0);

    run_op("store31", 3'd1, 7'd31, 16'h1234, 0, lat, rdy_n, data, wes, we_n, we_data);
    check("store31/wes",   wes, 32'd1);
    check("store31/we_n",  we_n, 32'd1);
    check("store31/wdata", {16'd0, we_data}, 32'h1234);
    check("store31/rdy_n", rdy_n, 32'd2);
    run_op("load31", 3'd0, 7'd31, 16'h0000, 0, lat, rdy_n, data, wes, we_n, we_data);
    check("load31/lat",  lat, 32'd3);
    check("load31/data", {16'd0, data}, 32'h1234);

    run_op("add30", 3'd2, 7'd30, 16'h0002, 0, lat, rdy_n, data, wes, we_n, we_data);
    check("add30/lat",   lat, 32'd4);
    check("add30/old",   {16'd0, data}, 32'hFFFF);
    check("add30/we_n",  we_n, 32'd3);
    check("add30/wdata", {16'd0, we_data}, 32'h0001);
    check("add30/mem",   {16'd0, mem[30]}, 32'h0001);

    run_op("xor7", 3'd5, 7'd7, 16'h00FF, 0, lat, rdy_n, data, wes, we_n, we_data);
    check("xor7/old", {16'd0, data}, 32'h0F0F);
    check("xor7/mem", {16'd0, mem[7]}, 32'h0FF0);

    run_op("swap5", 3'd6, 7'd5, 16'hAAAA, 4, lat, rdy_n, data, wes, we_n, we_data);
    check("swap5/lat", lat, 32'd4);
    check("swap5/old", {16'd0, data}, 32'h5555);
    check("swap5/mem", {16'd0, mem[5]}, 32'hAAAA);

    run_op("and127", 3'd3, 7'd127, 16'h0F0F, 1, lat, rdy_n, data, wes, we_n, we_data);
    check("and127/old", {16'd0, data}, 32'hBEEF);
    check("and127/mem", {16'd0, mem[127]}, 32'h0E0F);

    run_op("or0", 3'd4, 7'd0, 16'h00F0, 0, lat, rdy_n, data, wes, we_n, we_data);
    check("or0/old", {16'd0, data}, 32'h1357);
    check("or0/mem", {16'd0, mem[0]}, 32'h13F7);

    // ADD to addr 40, reset asserted during its CAP cycle.
    bus.req_valid = 1'b1; bus.req_op = 3'd2; bus.req_addr = 7'd40; bus.req_wdata = 16'h0001;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    we0 = total_we;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstcap/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rstcap/mem_we",    {31'd0, bus.mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstcap/req_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("rstcap/no_write",  total_we - we0, 32'd0);
    check("rstcap/rsp_valid2", {31'd0, bus.rsp_valid}, 32'd0);
    check("rstcap/mem40",     {16'd0, mem[40]}, 32'h0100);
    @(negedge clk);

    run_op("nop", 3'd7, 7'd29, 16'hFFFF, 0, lat, rdy_n, data, wes, we_n, we_data);
    check("nop/rdy_n", rdy_n, 32'd1);
    check("nop/lat",   lat, 32'd0);
    check("nop/wes",   wes, 32'd0);
    run_op("nopload", 3'd0, 7'd29, 16'h0000, 0, lat, rdy_n, data, wes, we_n, we_data);
    check("nopload/lat",  lat, 32'd3);
    check("nopload/data", {16'd0, data}, 32'd22);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
